// File: rtl/alu_div_seq_pkg.sv
// Shared definitions for the sequential restoring divider:
// FSM state encoding, default operand width and counter sizing.
package alu_div_seq_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Width of the iteration counter that walks 0..width-1.
  function automatic int cnt_bits(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/alu_div_seq_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface alu_div_seq_if
  import alu_div_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  start;
  logic                  signed_op;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/alu_div_seq_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor magnitude and keep
// the difference only when it does not go negative.
module alu_div_seq_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  // The shifted remainder can reach 2*divisor-1, so it needs one extra bit.
  logic [W:0] shifted;
  logic       fits;

  assign shifted = {rem_i, quo_i[W-1]};
  assign fits    = (shifted >= {1'b0, divisor_i});

  // When the divisor fits, the difference is below the divisor and thus
  // representable in W bits, so a W-bit modular subtract is exact.
  assign rem_o = fits ? (shifted[W-1:0] - divisor_i) : shifted[W-1:0];
  assign quo_o = {quo_i[W-2:0], fits};

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring integer divider. One quotient bit per RUN cycle,
// signed operands handled by dividing magnitudes and fixing signs at the end.
// Quotient goes to LO, remainder to HI; results hold until overwritten.
module alu_div_seq
  import alu_div_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic           clock,
  input  logic           clear_n,
  alu_div_seq_if.slave   bus
);

  localparam int                 CNT_W    = cnt_bits(DATA_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;          // raw dividend captured on accept
  logic [DATA_WIDTH-1:0]   b_q, b_d;          // raw divisor captured on accept
  logic                    signed_q, signed_d;
  logic [DATA_WIDTH-1:0]   quo_q, quo_d;      // dividend magnitude shifting into quotient
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;      // partial remainder
  logic [DATA_WIDTH-1:0]   bmag_q, bmag_d;    // divisor magnitude
  logic                    sq_q, sq_d;        // quotient must be negated
  logic                    sr_q, sr_d;        // remainder must be negated
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0]   remainder_q, remainder_d;
  logic                    dbz_q, dbz_d;

  logic [DATA_WIDTH-1:0]   step_rem;
  logic [DATA_WIDTH-1:0]   step_quo;
  logic                    neg_a;
  logic                    neg_b;

  // Two's-complement negation; the same helper serves LOAD and FIX.
  // |MIN| comes out as 2^(W-1), which is exact in W-bit unsigned terms.
  function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] x);
    return ~x + DATA_WIDTH'(1);
  endfunction

  assign neg_a = signed_q & a_q[DATA_WIDTH-1];
  assign neg_b = signed_q & b_q[DATA_WIDTH-1];

  alu_div_seq_div_step #(
    .W (DATA_WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (bmag_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Next-state and datapath update for the IDLE/LOAD/RUN/FIX/DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    bmag_d      = bmag_q;
    sq_d        = sq_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d      = bus.dividend;
          b_d      = bus.divisor;
          signed_d = bus.signed_op;
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        quo_d  = neg_a ? negate(a_q) : a_q;
        bmag_d = neg_b ? negate(b_q) : b_q;
        rem_d  = '0;
        sq_d   = neg_a ^ neg_b;
        sr_d   = neg_a;
        cnt_d  = '0;
        if (b_q == '0) begin
          // Divide by zero skips the iteration and reports the raw dividend.
          quotient_d  = '1;
          remainder_d = a_q;
          dbz_d       = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        quo_d = step_quo;
        rem_d = step_rem;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FIX: begin
        // Truncating division: quotient sign is sa^sb, remainder follows dividend.
        quotient_d  = sq_q ? negate(quo_q) : quo_q;
        remainder_d = sr_q ? negate(rem_q) : rem_q;
        dbz_d       = 1'b0;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      bmag_q      <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      bmag_q      <= bmag_d;
      sq_q        <= sq_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Status decodes straight from the state register, so both are glitch-free.
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed testbench for alu_div_seq (32-bit).
module tb_alu_div_seq;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  logic clk = 1'b0;
  logic clear_n = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_div_seq_if #(.DATA_WIDTH(W)) div_if ();

  alu_div_seq #(.DATA_WIDTH(W)) dut (
    .clock   (clk),
    .clear_n (clear_n),
    .bus     (div_if)
  );

  // Issue one start (from a point #1 after a rising edge) and return at the
  // sample where done is seen, or after a 100-cycle budget.
  // lat = 1 at the first sample after the accepting edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int lat, output bit busy_ok);
    div_if.dividend  = a;
    div_if.divisor   = b;
    div_if.signed_op = s;
    div_if.start     = 1'b1;
    @(posedge clk); #1;
    div_if.start     = 1'b0;
    div_if.dividend  = ~a;
    div_if.divisor   = b ^ 32'h0000_0005;
    div_if.signed_op = ~s;
    lat = 1;
    busy_ok = div_if.busy;
    while (!div_if.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!div_if.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    div_if.start = 1'b0;
    div_if.signed_op = 1'b0;
    div_if.dividend = '0;
    div_if.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (div_if.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", div_if.busy); end
    tests_run++; if (div_if.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", div_if.done); end
    tests_run++; if (div_if.quotient !== 32'h0) begin tests_failed++; $display("FAIL reset_q got %h want 0", div_if.quotient); end
    tests_run++; if (div_if.remainder !== 32'h0) begin tests_failed++; $display("FAIL reset_r got %h want 0", div_if.remainder); end
    tests_run++; if (div_if.div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz got %b want 0", div_if.div_by_zero); end
    clear_n = 1'b1;
    @(posedge clk); #1;
    $display("[TB] reset: busy=%b done=%b q=%h r=%h", div_if.busy, div_if.done, div_if.quotient, div_if.remainder);
  endtask

  task automatic test_unsigned();
    int lat; bit bok;
    run_op(32'd100, 32'd7, 1'b0, lat, bok);
    $display("[TB] 100/7 u: lat=%0d q=%h r=%h", lat, div_if.quotient, div_if.remainder);
    tests_run++; if (lat !== 35) begin tests_failed++; $display("FAIL u_latency got %0d want 35", lat); end
    tests_run++; if (bok !== 1'b1) begin tests_failed++; $display("FAIL u_busy_hold got %b want 1", bok); end
    tests_run++; if (div_if.quotient !== 32'd14) begin tests_failed++; $display("FAIL u_q got %h want 0000000e", div_if.quotient); end
    tests_run++; if (div_if.remainder !== 32'd2) begin tests_failed++; $display("FAIL u_r got %h want 00000002", div_if.remainder); end
    tests_run++; if (div_if.div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL u_dbz got %b want 0", div_if.div_by_zero); end
    @(posedge clk); #1;
    tests_run++; if (div_if.done !== 1'b0) begin tests_failed++; $display("FAIL u_done_pulse got %b want 0", div_if.done); end
    tests_run++; if (div_if.busy !== 1'b0) begin tests_failed++; $display("FAIL u_busy_after got %b want 0", div_if.busy); end
    tests_run++; if (div_if.quotient !== 32'd14) begin tests_failed++; $display("FAIL u_q_held got %h want 0000000e", div_if.quotient); end
  endtask

  task automatic test_signed();
    vec_t tv[5];
    int lat; bit bok;
    tv[0] = '{a: 32'hFFFF_FF9C, b: 32'h0000_0007, s: 1'b1, q: 32'hFFFF_FFF2, r: 32'hFFFF_FFFE};
    tv[1] = '{a: 32'h0000_0064, b: 32'hFFFF_FFF9, s: 1'b1, q: 32'hFFFF_FFF2, r: 32'h0000_0002};
    tv[2] = '{a: 32'hFFFF_FF9C, b: 32'hFFFF_FFF9, s: 1'b1, q: 32'h0000_000E, r: 32'hFFFF_FFFE};
    tv[3] = '{a: 32'h0000_0007, b: 32'h0000_0064, s: 1'b0, q: 32'h0000_0000, r: 32'h0000_0007};
    tv[4] = '{a: 32'hFFFF_FF9C, b: 32'h0000_0007, s: 1'b0, q: 32'h2492_4916, r: 32'h0000_0002};
    for (int i = 0; i < 5; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].s, lat, bok);
      $display("[TB] signed[%0d] %h/%h s=%b: lat=%0d q=%h r=%h", i, tv[i].a, tv[i].b, tv[i].s, lat, div_if.quotient, div_if.remainder);
      tests_run++; if (lat !== 35) begin tests_failed++; $display("FAIL signed_lat[%0d] got %0d want 35", i, lat); end
      tests_run++; if (div_if.quotient !== tv[i].q) begin tests_failed++; $display("FAIL signed_q[%0d] got %h want %h", i, div_if.quotient, tv[i].q); end
      tests_run++; if (div_if.remainder !== tv[i].r) begin tests_failed++; $display("FAIL signed_r[%0d] got %h want %h", i, div_if.remainder, tv[i].r); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int lat; bit bok;
    run_op(32'h0000_1234, 32'h0, 1'b0, lat, bok);
    $display("[TB] 1234/0 u: lat=%0d q=%h r=%h dbz=%b", lat, div_if.quotient, div_if.remainder, div_if.div_by_zero);
    tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL dz_latency got %0d want 2", lat); end
    tests_run++; if (div_if.quotient !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL dz_q got %h want ffffffff", div_if.quotient); end
    tests_run++; if (div_if.remainder !== 32'h0000_1234) begin tests_failed++; $display("FAIL dz_r got %h want 00001234", div_if.remainder); end
    tests_run++; if (div_if.div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL dz_flag got %b want 1", div_if.div_by_zero); end
    @(posedge clk); #1;
    run_op(32'hFFFF_FF9C, 32'h0, 1'b1, lat, bok);
    $display("[TB] ffffff9c/0 s: lat=%0d q=%h r=%h dbz=%b", lat, div_if.quotient, div_if.remainder, div_if.div_by_zero);
    tests_run++; if (div_if.remainder !== 32'hFFFF_FF9C) begin tests_failed++; $display("FAIL dz_signed_r got %h want ffffff9c", div_if.remainder); end
    tests_run++; if (div_if.div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL dz_signed_flag got %b want 1", div_if.div_by_zero); end
    @(posedge clk); #1;
    run_op(32'd100, 32'd7, 1'b0, lat, bok);
    $display("[TB] 100/7 after dz: dbz=%b", div_if.div_by_zero);
    tests_run++; if (div_if.div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL dz_cleared got %b want 0", div_if.div_by_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_boundary();
    vec_t tv[6];
    int lat; bit bok;
    tv[0] = '{a: 32'h8000_0000, b: 32'hFFFF_FFFF, s: 1'b1, q: 32'h8000_0000, r: 32'h0000_0000};
    tv[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, s: 1'b0, q: 32'hFFFF_FFFF, r: 32'h0000_0000};
    tv[2] = '{a: 32'h8000_0000, b: 32'h0000_0001, s: 1'b1, q: 32'h8000_0000, r: 32'h0000_0000};
    tv[3] = '{a: 32'h8000_0000, b: 32'hFFFF_FFFF, s: 1'b0, q: 32'h0000_0000, r: 32'h8000_0000};
    tv[4] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, s: 1'b0, q: 32'h0000_0001, r: 32'h0000_0000};
    tv[5] = '{a: 32'h0000_0005, b: 32'hFFFF_FFFF, s: 1'b1, q: 32'hFFFF_FFFB, r: 32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].s, lat, bok);
      $display("[TB] bound[%0d] %h/%h s=%b: lat=%0d q=%h r=%h dbz=%b", i, tv[i].a, tv[i].b, tv[i].s, lat, div_if.quotient, div_if.remainder, div_if.div_by_zero);
      tests_run++; if (div_if.quotient !== tv[i].q) begin tests_failed++; $display("FAIL bound_q[%0d] got %h want %h", i, div_if.quotient, tv[i].q); end
      tests_run++; if (div_if.remainder !== tv[i].r) begin tests_failed++; $display("FAIL bound_r[%0d] got %h want %h", i, div_if.remainder, tv[i].r); end
      tests_run++; if (div_if.div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL bound_dbz[%0d] got %b want 0", i, div_if.div_by_zero); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int dones;
    div_if.dividend = 32'd100; div_if.divisor = 32'd7; div_if.signed_op = 1'b0; div_if.start = 1'b1;
    @(posedge clk); #1;
    div_if.start = 1'b0;
    lat = 1;
    while (!div_if.done && lat < 100) begin
      if (lat == 10) begin
        div_if.dividend = 32'd50; div_if.divisor = 32'd3; div_if.signed_op = 1'b1; div_if.start = 1'b1;
      end
      @(posedge clk); #1;
      div_if.start = 1'b0;
      lat++;
    end
    $display("[TB] mid-run start: lat=%0d q=%h r=%h", lat, div_if.quotient, div_if.remainder);
    tests_run++; if (lat !== 35) begin tests_failed++; $display("FAIL ign_latency got %0d want 35", lat); end
    tests_run++; if (div_if.quotient !== 32'd14) begin tests_failed++; $display("FAIL ign_q got %h want 0000000e", div_if.quotient); end
    tests_run++; if (div_if.remainder !== 32'd2) begin tests_failed++; $display("FAIL ign_r got %h want 00000002", div_if.remainder); end
    // A start presented during the DONE cycle must also be dropped.
    div_if.dividend = 32'd50; div_if.divisor = 32'd3; div_if.start = 1'b1;
    @(posedge clk); #1;
    div_if.start = 1'b0;
    dones = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (div_if.busy || div_if.done) dones++;
    end
    $display("[TB] start in DONE: busy/done samples=%0d q=%h", dones, div_if.quotient);
    tests_run++; if (dones !== 0) begin tests_failed++; $display("FAIL ign_done_start got %0d busy samples want 0", dones); end
    tests_run++; if (div_if.quotient !== 32'd14) begin tests_failed++; $display("FAIL ign_done_q got %h want 0000000e", div_if.quotient); end
  endtask

  task automatic test_abort();
    int lat; bit bok;
    int dones;
    div_if.dividend = 32'd100; div_if.divisor = 32'd7; div_if.signed_op = 1'b0; div_if.start = 1'b1;
    @(posedge clk); #1;
    div_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    clear_n = 1'b0;
    @(posedge clk); #1;
    clear_n = 1'b1;
    $display("[TB] abort: busy=%b q=%h r=%h", div_if.busy, div_if.quotient, div_if.remainder);
    tests_run++; if (div_if.busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got %b want 0", div_if.busy); end
    tests_run++; if (div_if.quotient !== 32'h0) begin tests_failed++; $display("FAIL abort_q got %h want 0", div_if.quotient); end
    tests_run++; if (div_if.remainder !== 32'h0) begin tests_failed++; $display("FAIL abort_r got %h want 0", div_if.remainder); end
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_if.done) dones++;
    end
    tests_run++; if (dones !== 0) begin tests_failed++; $display("FAIL abort_no_done got %0d want 0", dones); end
    run_op(32'd1000, 32'd10, 1'b0, lat, bok);
    $display("[TB] after abort 1000/10: lat=%0d q=%h r=%h", lat, div_if.quotient, div_if.remainder);
    tests_run++; if (lat !== 35) begin tests_failed++; $display("FAIL abort_next_lat got %0d want 35", lat); end
    tests_run++; if (div_if.quotient !== 32'd100) begin tests_failed++; $display("FAIL abort_next_q got %h want 00000064", div_if.quotient); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; bit bok;
    run_op(32'd100, 32'd7, 1'b0, lat, bok);
    $display("[TB] b2b first: q=%h r=%h", div_if.quotient, div_if.remainder);
    // Hold start through the DONE cycle; only the following cycle may accept.
    div_if.dividend = 32'd200; div_if.divisor = 32'd9; div_if.signed_op = 1'b0; div_if.start = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (div_if.busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_accept busy got %b want 0", div_if.busy); end
    run_op(32'd200, 32'd9, 1'b0, lat, bok);
    $display("[TB] b2b second 200/9: lat=%0d q=%h r=%h", lat, div_if.quotient, div_if.remainder);
    tests_run++; if (lat !== 35) begin tests_failed++; $display("FAIL b2b_lat got %0d want 35", lat); end
    tests_run++; if (div_if.quotient !== 32'd22) begin tests_failed++; $display("FAIL b2b_q got %h want 00000016", div_if.quotient); end
    tests_run++; if (div_if.remainder !== 32'd2) begin tests_failed++; $display("FAIL b2b_r got %h want 00000002", div_if.remainder); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_boundary();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
